// File: rtl/serial_loader.sv
// serial_loader: UART-driven memory programmer.
// It receives a frame from the serial receiver: SYNC byte, then a little-endian
// 16-bit start address, a little-endian 16-bit length N, N data bytes, and a
// checksum byte. Each data byte is written to memory through a one-stage write
// pipeline. The frame is good when the data bytes plus the checksum byte sum to
// 0 mod 256.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   rx_byte     received byte, valid while rx_ready=1
//   rx_ready    single-cycle receive strobe, already synchronous to clk
//   mem_addr    write address (ADDR_W bits)
//   mem_data    write data
//   mem_wren    one-cycle write strobe
//   busy        frame in progress (holds the CPU in reset)
//   done        one-cycle pulse at the end of a good frame
//   err_csum    sticky checksum-mismatch flag, cleared by the next SYNC
//   err_timeout sticky inter-byte timeout flag, cleared by the next SYNC
module serial_loader #(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 2500000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              err_csum,
  output logic              err_timeout
);

  // Width of the inter-byte timer; sized so it can hold TIMEOUT itself.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    A_LO,
    A_HI,
    L_LO,
    L_HI,
    DATA,
    CSUM
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [7:0]     addr_lo;
  logic [7:0]     len_lo;
  logic [15:0]    remaining;
  logic [7:0]     sum;
  logic [TW-1:0]  tcnt;

  logic           accept_sync;
  logic           cap_alo;
  logic           cap_ahi;
  logic           cap_llo;
  logic           cap_lhi;
  logic           wr_byte;
  logic           csum_good;
  logic           csum_bad;
  logic           timeout_hit;
  logic [7:0]     csum_total;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-byte action decode.
  // When a byte and the timer expiry land on the same cycle, the byte wins.
  always_comb begin
    state_next  = state;
    accept_sync = 1'b0;
    cap_alo     = 1'b0;
    cap_ahi     = 1'b0;
    cap_llo     = 1'b0;
    cap_lhi     = 1'b0;
    wr_byte     = 1'b0;
    csum_good   = 1'b0;
    csum_bad    = 1'b0;
    csum_total  = sum + rx_byte;
    timeout_hit = (TIMEOUT != 0) && (state != IDLE) && !rx_ready &&
                  (tcnt == TW'(TIMEOUT));

    if (timeout_hit) begin
      state_next = IDLE;
    end else if (rx_ready) begin
      case (state)
        IDLE: begin
          if (rx_byte == SYNC) begin
            accept_sync = 1'b1;
            state_next  = A_LO;
          end
        end
        A_LO: begin
          cap_alo    = 1'b1;
          state_next = A_HI;
        end
        A_HI: begin
          cap_ahi    = 1'b1;
          state_next = L_LO;
        end
        L_LO: begin
          cap_llo    = 1'b1;
          state_next = L_HI;
        end
        L_HI: begin
          cap_lhi    = 1'b1;
          state_next = ({rx_byte, len_lo} == 16'd0) ? CSUM : DATA;
        end
        DATA: begin
          wr_byte    = 1'b1;
          state_next = (remaining == 16'd1) ? CSUM : DATA;
        end
        CSUM: begin
          csum_good  = (csum_total == 8'd0);
          csum_bad   = (csum_total != 8'd0);
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Header capture, length countdown and running checksum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_lo   <= 8'd0;
      len_lo    <= 8'd0;
      remaining <= 16'd0;
      sum       <= 8'd0;
    end else begin
      if (cap_alo) begin
        addr_lo <= rx_byte;
      end
      if (cap_llo) begin
        len_lo <= rx_byte;
      end
      if (cap_lhi) begin
        remaining <= {rx_byte, len_lo};
      end else if (wr_byte) begin
        remaining <= remaining - 16'd1;
      end
      if (accept_sync) begin
        sum <= 8'd0;
      end else if (wr_byte) begin
        sum <= sum + rx_byte;
      end
    end
  end

  // Write pipeline: strobe one cycle after the byte, address advances the
  // cycle after the strobe so it is stable while mem_wren is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
      mem_data <= 8'd0;
      mem_wren <= 1'b0;
    end else begin
      mem_wren <= wr_byte;
      if (wr_byte) begin
        mem_data <= rx_byte;
      end
      if (cap_ahi) begin
        mem_addr <= ADDR_W'({rx_byte, addr_lo});
      end else if (mem_wren) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

  // Status outputs: busy spans the frame, error flags are sticky until SYNC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= csum_good;
      if (accept_sync) begin
        busy        <= 1'b1;
        err_csum    <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (csum_good || csum_bad || timeout_hit) begin
          busy <= 1'b0;
        end
        if (csum_bad) begin
          err_csum <= 1'b1;
        end
        if (timeout_hit) begin
          err_timeout <= 1'b1;
        end
      end
    end
  end

  // Inter-byte timer: cleared by every byte, runs only inside a frame and
  // saturates at TIMEOUT. With TIMEOUT=0 it is held at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (rx_ready || state == IDLE) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: directed bench for serial_loader (ADDR_W=14, SYNC=A5,
// TIMEOUT=100). Frame vectors are applied from a table; timeout, byte-vs-timeout
// collision and asynchronous reset mid-frame are hand-written sequences.
module tb_serial_loader;

  localparam int unsigned AW = 14;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    rx_byte;
  logic          rx_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_wren;
  logic          busy;
  logic          done;
  logic          err_csum;
  logic          err_timeout;

  always #5 clk = ~clk;

  serial_loader #(.ADDR_W(AW), .SYNC(8'hA5), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_byte     (rx_byte),
    .rx_ready    (rx_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .busy        (busy),
    .done        (done),
    .err_csum    (err_csum),
    .err_timeout (err_timeout)
  );

  // Frame bytes are left-aligned: byte 0 is fr[79:72]. Expected write
  // addresses/data are left-aligned the same way.
  typedef struct {
    logic [79:0] fr;
    int          n;
    int          s;
    int          nw;
    logic [41:0] wa;
    logic [23:0] wd;
    logic        dn;
    logic        ec;
  } vec_t;

  int            n_cmp = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  logic [21:0]   wr_q[$];
  vec_t          vecs[5];

  // Write/done monitor, sampled 2 ns after the active edge.
  always @(posedge clk) begin
    #2;
    if (mem_wren) wr_q.push_back({mem_addr, mem_data});
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wr_q.delete();
    done_cnt = 0;
    for (int i = 0; i < v.n; i++) begin
      send(v.fr[79-8*i -: 8]);
      if (i < v.s) chk($sformatf("v%0d_busy_pre%0d", idx, i), 32'(busy), 32'd0);
      if (i == v.s) begin
        chk($sformatf("v%0d_busy_sync", idx), 32'(busy), 32'd1);
        chk($sformatf("v%0d_csum_clr", idx), 32'(err_csum), 32'd0);
        chk($sformatf("v%0d_tmo_clr", idx), 32'(err_timeout), 32'd0);
      end
    end
    chk($sformatf("v%0d_done_edge", idx), 32'(done), 32'(v.dn));
    chk($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d_csum_edge", idx), 32'(err_csum), 32'(v.ec));
    idle(3);
    chk($sformatf("v%0d_done_cnt", idx), 32'(done_cnt), 32'(v.dn));
    chk($sformatf("v%0d_nwrites", idx), 32'(wr_q.size()), 32'(v.nw));
    for (int j = 0; j < v.nw; j++) begin
      if (j < wr_q.size()) begin
        chk($sformatf("v%0d_waddr%0d", idx, j), 32'(wr_q[j][21:8]), 32'(v.wa[41-14*j -: 14]));
        chk($sformatf("v%0d_wdata%0d", idx, j), 32'(wr_q[j][7:0]), 32'(v.wd[23-8*j -: 8]));
      end
    end
    chk($sformatf("v%0d_csum_sticky", idx), 32'(err_csum), 32'(v.ec));
    chk($sformatf("v%0d_tmo", idx), 32'(err_timeout), 32'd0);
  endtask

  initial begin
    vecs[0] = '{fr: 80'hA5_00_01_03_00_11_22_33_9A_00, n: 9, s: 0, nw: 3,
                wa: {14'h0100, 14'h0101, 14'h0102}, wd: 24'h112233, dn: 1'b1, ec: 1'b0};
    vecs[1] = '{fr: 80'hA5_00_01_03_00_11_22_33_9B_00, n: 9, s: 0, nw: 3,
                wa: {14'h0100, 14'h0101, 14'h0102}, wd: 24'h112233, dn: 1'b0, ec: 1'b1};
    vecs[2] = '{fr: 80'hA5_FF_3F_02_00_01_02_FD_00_00, n: 8, s: 0, nw: 2,
                wa: {14'h3FFF, 14'h0000, 14'h0000}, wd: 24'h010200, dn: 1'b1, ec: 1'b0};
    vecs[3] = '{fr: 80'hA5_34_12_00_00_00_00_00_00_00, n: 6, s: 0, nw: 0,
                wa: 42'd0, wd: 24'd0, dn: 1'b1, ec: 1'b0};
    vecs[4] = '{fr: 80'h00_FF_5A_A5_00_01_01_00_7E_82, n: 10, s: 3, nw: 1,
                wa: {14'h0100, 28'd0}, wd: 24'h7E0000, dn: 1'b1, ec: 1'b0};

    reset_n  = 1'b0;
    rx_ready = 1'b0;
    rx_byte  = 8'h00;
    #1;
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_csum", 32'(err_csum), 32'd0);
    chk("rst_tmo", 32'(err_timeout), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Timeout after A_HI: counter reaches 100 after 100 idle clocks, fires on the next.
    done_cnt = 0;
    send(8'hA5);
    send(8'h00);
    idle(100);
    chk("tmo_not_yet", 32'(err_timeout), 32'd0);
    chk("tmo_busy_held", 32'(busy), 32'd1);
    idle(1);
    chk("tmo_fired", 32'(err_timeout), 32'd1);
    chk("tmo_busy_drop", 32'(busy), 32'd0);
    idle(5);
    chk("tmo_sticky", 32'(err_timeout), 32'd1);
    chk("tmo_no_done", 32'(done_cnt), 32'd0);
    run_vec(vecs[0], 10);

    // Byte arrives on the very cycle the timer hits TIMEOUT: byte wins.
    send(8'hA5);
    idle(99);
    send(8'h01);
    chk("race_no_tmo", 32'(err_timeout), 32'd0);
    chk("race_busy", 32'(busy), 32'd1);
    send(8'h01);
    send(8'h02);
    send(8'h00);
    wr_q.delete();
    done_cnt = 0;
    send(8'h55);
    chk("mid_wren", 32'(mem_wren), 32'd1);
    chk("mid_addr", 32'(mem_addr), 32'h0101);
    chk("mid_data", 32'(mem_data), 32'h55);

    // Asynchronous reset mid-DATA clears all outputs without waiting for a clock.
    reset_n = 1'b0;
    #1;
    chk("arst_wren", 32'(mem_wren), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_data", 32'(mem_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_flags", 32'({done, err_csum, err_timeout}), 32'd0);
    #1;
    reset_n = 1'b1;
    idle(2);
    send(8'h66);
    send(8'h00);
    idle(3);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_writes", 32'(wr_q.size()), 32'd1);
    chk("post_rst_done", 32'(done_cnt), 32'd0);
    chk("post_rst_flags", 32'({err_csum, err_timeout}), 32'd0);
    run_vec(vecs[0], 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
